// File: rtl/boot_mem_loader_pkg.sv
// Shared definitions for the boot memory loader.
//   boot_state_t : loader phases (IDLE, LOAD, CHECK, DONE, ERROR)
//   csum_add     : checksum accumulate; callers truncate the result to their
//                  word width, which yields modulo-2^WIDTH wrap (WIDTH <= 64)
package boot_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } boot_state_t;

  function automatic logic [63:0] csum_add(input logic [63:0] a, input logic [63:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/boot_mem_loader_if.sv
// Bus bundle between a host and boot_mem_loader.
//   load_*        : boot stream handshake plus start pulse
//   csum_expected : reference checksum for the loaded image
//   rd_* / wr_*   : host read port (1-cycle latency) and host write port
//   busy / boot_done / boot_error : loader status
// master = host side, slave = boot_mem_loader side.
interface boot_mem_loader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
);
  logic             load_start;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic [WIDTH-1:0] csum_expected;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             boot_done;
  logic             boot_error;

  modport master (
    output load_start, load_valid, load_data, csum_expected,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  load_ready, rd_data, rd_valid, busy, boot_done, boot_error
  );

  modport slave (
    input  load_start, load_valid, load_data, csum_expected,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output load_ready, rd_data, rd_valid, busy, boot_done, boot_error
  );
endinterface

// File: rtl/boot_mem_loader_array.sv
// Single-write, single-registered-read memory, read-first on address
// collision. Contents are not reset.
//   clk   : clock
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata updates one cycle later and holds
//                    its value while re is low
module boot_mem_array #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write in the same block: the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/boot_mem_loader.sv
// Boot memory with stream loader, checksum verification and post-boot lock.
//   clk, reset (sync, active-low)
//   bus           : boot_mem_loader_if slave (load stream, host rd/wr, status)
//   scan_in0..4, scan_enable, test_mode : DFT hooks, unused functionally
//   scan_out0..4  : DFT outputs, tied low
module boot_mem_loader
  import boot_mem_pkg::*;
#(
  parameter int DEPTH           = 128,
  parameter int WIDTH           = 32,
  parameter int AW              = $clog2(DEPTH),
  parameter bit LOCK_AFTER_BOOT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  boot_mem_loader_if.slave   bus,
  input  logic               scan_in0,
  input  logic               scan_in1,
  input  logic               scan_in2,
  input  logic               scan_in3,
  input  logic               scan_in4,
  input  logic               scan_enable,
  input  logic               test_mode,
  output logic               scan_out0,
  output logic               scan_out1,
  output logic               scan_out2,
  output logic               scan_out3,
  output logic               scan_out4
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_CHECK = CHECK;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ERROR = ERROR;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [2:0]       state, state_nx;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] csum;
  logic             lock;
  logic             load_ready_r, busy_r, done_r, error_r, rd_valid_r;
  logic             rd_seen;
  logic             accept, host_wr, rd_fire, mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  // Scan stitching happens at insertion; the RTL only parks these.
  logic unused_scan;
  assign unused_scan = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  function automatic logic [WIDTH-1:0] csum_wrap(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return WIDTH'(csum_add(64'(a), 64'(b)));
  endfunction

  // load_ready is exactly "state is LOAD", so the handshake uses state directly.
  assign accept  = (state == S_LOAD) && bus.load_valid;
  assign host_wr = bus.wr_en && ((state == S_IDLE) || (state == S_ERROR) ||
                                 ((state == S_DONE) && !lock));
  assign rd_fire = bus.rd_en && ((state == S_IDLE) || (state == S_DONE) ||
                                 (state == S_ERROR));

  // Loader owns the write port during LOAD, host otherwise.
  assign mem_we    = reset && (accept || host_wr);
  assign mem_waddr = (state == S_LOAD) ? ptr : bus.wr_addr;
  assign mem_wdata = (state == S_LOAD) ? bus.load_data : bus.wr_data;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.load_start) state_nx = S_LOAD;
      S_LOAD:  if (accept && (ptr == LAST_ADDR)) state_nx = S_CHECK;
      S_CHECK: state_nx = (csum == bus.csum_expected) ? S_DONE : S_ERROR;
      S_DONE:  if (bus.load_start && !lock) state_nx = S_LOAD;
      S_ERROR: if (bus.load_start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      csum         <= '0;
      lock         <= 1'b0;
      load_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_seen      <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state != S_LOAD) && (state_nx == S_LOAD)) begin
        ptr  <= '0;
        csum <= '0;
      end else if (accept) begin
        ptr  <= ptr + 1'b1;
        csum <= csum_wrap(csum, bus.load_data);
      end
      lock         <= LOCK_AFTER_BOOT && (state_nx == S_DONE);
      load_ready_r <= (state_nx == S_LOAD);
      busy_r       <= (state_nx == S_LOAD) || (state_nx == S_CHECK);
      done_r       <= (state_nx == S_DONE);
      error_r      <= (state_nx == S_ERROR);
      rd_valid_r   <= rd_fire;
      if (rd_fire) rd_seen <= 1'b1;
    end
  end

  boot_mem_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (reset && rd_fire),
    .raddr (bus.rd_addr),
    .rdata (mem_rdata)
  );

  // The array output has no reset; mask it until the first read after reset.
  assign bus.rd_data    = rd_seen ? mem_rdata : '0;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.load_ready = load_ready_r;
  assign bus.busy       = busy_r;
  assign bus.boot_done  = done_r;
  assign bus.boot_error = error_r;

endmodule
